job_scheduler: RTL
==================

# job_scheduler

Shares one start/done/error job engine (the single-job sequencing controller in this design) between `NUM_REQ` requesters. It does this by round-robin arbitration, launching and sequencing each job, retrying failed jobs, and returning a per-requester completion response. It sits between the requester ports and the engine and is the only block that drives engine `start` and `clear`.

## Interface
- `NUM_REQ`, 4: number of requesters; must be 2 or more.
- `MAX_RETRY`, 2: number of re-launches after an engine error before a job is reported as faulted; must be 0 or more.
- `TIMEOUT_CYCLES`, 1024: maximum number of WAIT cycles before a job is treated as failed. Only used when the timeout feature is compiled in.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `req` in NUM_REQ: level request per requester.
- `grant` out NUM_REQ: one-hot; identifies the requester that owns the engine.
- `eng_start` out 1: one-cycle launch pulse to the engine.
- `eng_clear` out 1: one-cycle pulse that returns the engine to idle.
- `eng_done` in 1: engine completed successfully.
- `eng_error` in 1: engine reports an error.
- `rsp_valid` out 1: one-cycle completion strobe.
- `rsp_id` out $clog2(NUM_REQ): index of the requester that owns the response.
- `rsp_fault` out 1: job failed after all retries; valid while `rsp_valid` is high.
- `rsp_timeout` out 1: the final failure was a timeout; valid while `rsp_valid` is high.
- `busy` out 1: high in every state except IDLE.

## Operation
- Moore FSM with states IDLE, LAUNCH, WAIT, CLEAR, RESP. All outputs are decoded from registered state and registers only.
- IDLE:
  - If any `req` bit is high, the round-robin pick starts at pointer `ptr`, and the winner is registered into `owner`.
  - Retry count is zeroed; next state is LAUNCH.
- LAUNCH: `eng_start`=1 for exactly one cycle; next state is WAIT.
- WAIT, evaluated in priority order:
  - `eng_error` high (also wins over a simultaneous `eng_done`): go to CLEAR if `retry < MAX_RETRY`, otherwise go to RESP with fault.
  - `eng_done` high: go to RESP with ok.
  - Otherwise stay in WAIT.
- CLEAR: `eng_clear`=1 and `retry` increments; next state is LAUNCH.
- RESP:
  - `rsp_valid`=1, `rsp_id`=`owner`, `eng_clear`=1.
  - `ptr` is set to `owner`+1, wrapping from NUM_REQ-1 to 0.
  - Next state is IDLE.
- `grant[owner]` is high from LAUNCH through RESP inclusive and is zero in IDLE.
- `req` is not sampled outside IDLE. A requester that still holds `req` high in the cycle after `rsp_valid` is treated as issuing a new job. Rotation gives every other pending requester service first.
- `eng_done` and `eng_error` are ignored outside WAIT.
- Reset (may occur in any state) gives:
  - state IDLE, `ptr`=0, `owner`=0, `retry`=0, timer=0.
  - All outputs 0: `grant`=0, `eng_start`=0, `eng_clear`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_fault`=0, `rsp_timeout`=0, `busy`=0.
  - The engine shares this reset.

## Timing
- `req` first seen high in IDLE at cycle 0: `grant` and `eng_start` are high in cycle 1, and WAIT begins at cycle 2.
- `eng_done` high in WAIT at cycle k: `rsp_valid` is high in cycle k+1, IDLE in k+2, and the earliest next `eng_start` is in k+3.
- Each retry adds 2 cycles (CLEAR, then LAUNCH) before WAIT is re-entered.
- Best-case turnaround from one response to the next launch is 2 cycles.

## Configuration
- `JOB_SCHED_TIMEOUT_EN` defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit timer clears on WAIT entry and counts each WAIT cycle.
  - When the timer reaches TIMEOUT_CYCLES with neither `eng_done` nor `eng_error` seen, that cycle is handled exactly like `eng_error`.
  - A timeout-caused RESP fault sets `rsp_timeout`=1.
- `JOB_SCHED_TIMEOUT_EN` undefined: no timer is built, WAIT has no cycle limit, and `rsp_timeout` is tied to 0.

## Structure
- `job_sched_pkg`: state enum, and state encoding widths derived from the parameters.
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs are `req` and `ptr`; outputs are the winner index and an any-request flag.
- Retry counter, timer, `ptr` and the FSM live in `job_scheduler`.

## Test plan
- Single request: `req`=4'b0010 → `grant`=4'b0010 and `eng_start` in cycle 1; `eng_done` at cycle 5 → `rsp_valid` at cycle 6 with `rsp_id`=1, `rsp_fault`=0.
- All four requesters held high continuously, `eng_done` 3 cycles after each start → `rsp_id` sequence 0,1,2,3,0 with no requester served twice before the others.
- `eng_error` on every attempt with MAX_RETRY=2 → 3 `eng_start` pulses and 2 CLEAR-state `eng_clear` pulses, then `rsp_fault`=1.
- `eng_done` and `eng_error` high in the same cycle → handled as error (retry path); a later clean `eng_done` → `rsp_fault`=0.
- With the macro defined and TIMEOUT_CYCLES=8: engine silent → exactly 8 WAIT cycles then CLEAR; after the final attempt, `rsp_fault`=1 and `rsp_timeout`=1. With the macro undefined: still in WAIT after 100 cycles.
- `reset` asserted while in WAIT with `grant`=4'b0100 → next cycle all outputs are 0 and state is IDLE; the first grant after reset goes to the lowest pending index, since `ptr`=0.

Source files
------------

// File: rtl/job_sched_pkg.sv
// rtl/job_sched_pkg.sv - state encoding and width helpers shared by job_scheduler
package job_sched_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_CLEAR  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // Width of a counter holding values 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/job_sched_rr_arbiter.sv
// rtl/job_sched_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import job_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr < NUM_REQ and i < NUM_REQ, so one subtraction wraps the index
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/job_scheduler.sv
// rtl/job_scheduler.sv - round-robin job launcher with retry; JOB_SCHED_TIMEOUT_EN adds a WAIT watchdog
module job_scheduler
  import job_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_RETRY      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       eng_start,
  output logic                       eng_clear,
  input  logic                       eng_done,
  input  logic                       eng_error,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_fault,
  output logic                       rsp_timeout,
  output logic                       busy
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int RETRY_W = idx_w(MAX_RETRY + 1);

  state_t              state, state_nx;
  logic [ID_W-1:0]     ptr, owner, winner;
  logic [RETRY_W-1:0]  retry;
  logic                any_req, fault_q, timeout_hit, err_evt, retry_left;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef JOB_SCHED_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer;
  logic               tmo_q;

  // Timer is zeroed in LAUNCH so it reads 0 on the first WAIT cycle of every attempt.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
      tmo_q <= 1'b0;
    end else begin
      if (state == S_LAUNCH)    timer <= '0;
      else if (state == S_WAIT) timer <= timer + 1'b1;
      if (state == S_WAIT && state_nx == S_RESP) tmo_q <= timeout_hit && !eng_error;
    end
  end

  assign timeout_hit = (state == S_WAIT) && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = (state == S_RESP) && tmo_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign rsp_timeout        = 1'b0;
`endif

  assign err_evt    = eng_error || timeout_hit;
  assign retry_left = (retry < RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (any_req) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT: begin
        if (err_evt)       state_nx = retry_left ? S_CLEAR : S_RESP;
        else if (eng_done) state_nx = S_RESP;
      end
      S_CLEAR:  state_nx = S_LAUNCH;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      owner   <= '0;
      retry   <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          owner <= winner;
          retry <= '0;
        end
        S_WAIT:  if (state_nx == S_RESP) fault_q <= err_evt;
        S_CLEAR: retry <= retry + 1'b1;
        S_RESP:  ptr <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    grant     = '0;
    eng_start = (state == S_LAUNCH);
    eng_clear = (state == S_CLEAR) || (state == S_RESP);
    rsp_valid = (state == S_RESP);
    rsp_id    = (state == S_RESP) ? owner : '0;
    rsp_fault = (state == S_RESP) && fault_q;
    busy      = (state != S_IDLE);
    if (state != S_IDLE) grant[owner] = 1'b1;
  end

endmodule
